// File: rtl/ad9518_spi_config.sv
// Boot-time AD9518 SPI write engine: walks the config LUT and sends each entry as a 24-bit write frame.
// Define AD9518_LOCK_WAIT_EN to wait for PLL lock (pll_ld) before reporting done.
module ad9518_spi_config #(
  parameter int CLK_DIV    = 2,
  parameter int LUT_SIZE   = 37,
  parameter int RESET_WAIT = 1000,
  parameter int GAP_CYCLES = 4
`ifdef AD9518_LOCK_WAIT_EN
  , parameter int LOCK_TIMEOUT = 1 << 20
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        spi_csn,
  output logic        spi_sclk,
  output logic        spi_sdio,
  input  logic        pll_ld,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_MAX = (RESET_WAIT > GAP_CYCLES) ? RESET_WAIT : GAP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int HALVES   = 49;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_FINISH
`ifdef AD9518_LOCK_WAIT_EN
    , S_LOCK
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [9:0]          r_idx, w_idx_nxt;
  logic [23:0]         r_shift, w_shift_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [5:0]          r_half, w_half_nxt;
  logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_csn, r_sclk, r_sdio, r_busy, r_done;
  logic                w_csn_nxt, w_sclk_nxt, w_sdio_nxt, w_busy_nxt, w_done_nxt;
  logic                w_div_last, w_table_end;
  logic [23:0]         w_frame;
  int                  w_wait;

`ifdef AD9518_LOCK_WAIT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  logic            r_ld_meta, r_ld_sync, r_error, w_error_nxt;
  logic [7:0]      r_lk_cnt, w_lk_nxt;
  logic [TO_W-1:0] r_to, w_to_nxt;
  assign error = r_error;
`else
  logic w_unused_ld;
  assign w_unused_ld = pll_ld;
  assign error = 1'b0;
`endif

  assign lut_index = r_idx;
  assign spi_csn   = r_csn;
  assign spi_sclk  = r_sclk;
  assign spi_sdio  = r_sdio;
  assign busy      = r_busy;
  assign done      = r_done;

  assign w_frame     = {1'b0, 2'b00, lut_data[20:8], lut_data[7:0]};
  assign w_table_end = (lut_data[23:8] == 16'hFFFF) || (r_idx == 10'(LUT_SIZE));
  assign w_div_last  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_wait      = (r_idx == '0) ? RESET_WAIT : GAP_CYCLES;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_half_nxt  = r_half;
    w_cnt_nxt   = r_cnt;
    w_csn_nxt   = r_csn;
    w_sclk_nxt  = r_sclk;
    w_sdio_nxt  = r_sdio;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
`ifdef AD9518_LOCK_WAIT_EN
    w_error_nxt = r_error;
    w_lk_nxt    = r_lk_cnt;
    w_to_nxt    = r_to;
`endif
    case (r_state)
      S_IDLE: if (start) begin
        w_idx_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
`ifdef AD9518_LOCK_WAIT_EN
        w_error_nxt = 1'b0;
`endif
        w_state_nxt = S_LOAD;
      end
      S_LOAD: if (w_table_end) begin
`ifdef AD9518_LOCK_WAIT_EN
        w_lk_nxt    = '0;
        w_to_nxt    = '0;
        w_state_nxt = S_LOCK;
`else
        w_state_nxt = S_FINISH;
`endif
      end else begin
        w_shift_nxt = w_frame;
        w_csn_nxt   = 1'b0;
        w_sdio_nxt  = w_frame[23];
        w_div_nxt   = '0;
        w_half_nxt  = '0;
        w_state_nxt = S_SHIFT;
      end
      // Half-period 0 is CSN setup; odd halves are sclk low, even (>0) are sclk high.
      S_SHIFT: begin
        w_div_nxt = r_div + 1'b1;
        if (w_div_last) begin
          w_div_nxt = '0;
          if (r_half == 6'(HALVES - 1)) begin
            w_sclk_nxt  = 1'b0;
            w_state_nxt = S_HOLD;
          end else begin
            w_half_nxt = r_half + 6'd1;
            w_sclk_nxt = r_half[0];
            if (!r_half[0] && (r_half != '0)) begin
              w_shift_nxt = {r_shift[22:0], 1'b0};
              w_sdio_nxt  = r_shift[22];
            end
          end
        end
      end
      S_HOLD: begin
        w_div_nxt = r_div + 1'b1;
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_csn_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end
      end
      // The following LOAD cycle also has CSN high, so it closes the gap.
      S_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (int'(r_cnt) + 2 >= w_wait) begin
          w_idx_nxt   = r_idx + 10'd1;
          w_state_nxt = S_LOAD;
        end
      end
`ifdef AD9518_LOCK_WAIT_EN
      S_LOCK: begin
        w_to_nxt = r_to + 1'b1;
        w_lk_nxt = r_ld_sync ? r_lk_cnt + 8'd1 : '0;
        if (r_ld_sync && (r_lk_cnt == 8'hFF)) begin
          w_state_nxt = S_FINISH;
        end else if (r_to == TO_W'(LOCK_TIMEOUT - 1)) begin
          w_error_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_FINISH: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_csn_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_div   <= '0;
      r_half  <= '0;
      r_cnt   <= '0;
      r_csn   <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdio  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_div   <= w_div_nxt;
      r_half  <= w_half_nxt;
      r_cnt   <= w_cnt_nxt;
      r_csn   <= w_csn_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdio  <= w_sdio_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef AD9518_LOCK_WAIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_meta <= 1'b0;
      r_ld_sync <= 1'b0;
      r_lk_cnt  <= '0;
      r_to      <= '0;
      r_error   <= 1'b0;
    end else begin
      r_ld_meta <= pll_ld;
      r_ld_sync <= r_ld_meta;
      r_lk_cnt  <= w_lk_nxt;
      r_to      <= w_to_nxt;
      r_error   <= w_error_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ad9518_spi_config.sv
// Self-checking bench for ad9518_spi_config: SPI frame decoder/model plus directed sequences.
`timescale 1ns/1ps
module tb_ad9518_spi_config;
  localparam int CLK_DIV    = 2;
  localparam int LUT_SIZE   = 37;
  localparam int RESET_WAIT = 1000;
  localparam int GAP_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pll_ld = 1'b0;
  logic [9:0]  lut_index;
  logic [23:0] lut_data;
  logic        spi_csn, spi_sclk, spi_sdio, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] lut_tbl [0:LUT_SIZE-1];
  logic        term_mode = 1'b0;
  int          test_id = 0;
  logic [23:0] cap [0:63];
  int          nfr;

  always #5 clk = ~clk;

  ad9518_spi_config #(
    .CLK_DIV(CLK_DIV), .LUT_SIZE(LUT_SIZE),
    .RESET_WAIT(RESET_WAIT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdio(spi_sdio), .pll_ld(pll_ld),
    .busy(busy), .done(done), .error(error)
  );

  always_comb begin
    if (term_mode && lut_index == 10'd5) lut_data = 24'hFFFFFF;
    else if (int'(lut_index) < LUT_SIZE) lut_data = lut_tbl[int'(lut_index)];
    else lut_data = 24'h0000AA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write frame on the wire: R/W=0, W1W0=00, 13-bit address, data byte.
  function automatic logic [23:0] exp_frame(input int i);
    logic [23:0] e;
    e = lut_tbl[i];
    return {1'b0, 2'b00, e[20:8], e[7:0]};
  endfunction

  // Decodes the SPI pins every cycle and compares against the LUT-derived model.
  initial begin : mon
    logic pc, ps, pd, in_frame, have_prev;
    int low_cnt, gap_cnt, nrise, last_id, exp_cnt, exp_gap;
    logic [23:0] shv;
    pc = 1'b1; ps = 1'b0; pd = 1'b0; in_frame = 1'b0; have_prev = 1'b0;
    low_cnt = 0; gap_cnt = 0; nrise = 0; last_id = 0; shv = '0; nfr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pc = 1'b1; ps = 1'b0; pd = 1'b0; in_frame = 1'b0; have_prev = 1'b0;
      end else begin
        if (test_id != last_id) begin
          last_id = test_id; nfr = 0; have_prev = 1'b0; in_frame = 1'b0;
        end
        exp_cnt = term_mode ? 5 : LUT_SIZE;
        if (!spi_csn) begin
          if (pc) begin
            in_frame = 1'b1; low_cnt = 0; nrise = 0; shv = '0;
            chk("frame_in_range", (nfr < exp_cnt), 1);
            chk("lut_index_at_frame", lut_index, nfr);
            if (have_prev) begin
              exp_gap = (nfr - 1 == 0) ? RESET_WAIT : GAP_CYCLES;
              chk("csn_gap", gap_cnt, exp_gap);
            end
          end
          low_cnt++;
          chk("busy_in_frame", busy, 1);
          if (!pc && spi_sdio !== pd) chk("sdio_moves_sclk_low", spi_sclk, 0);
          if (spi_sclk && !ps) begin
            shv = {shv[22:0], spi_sdio};
            nrise++;
          end
        end else begin
          chk("sclk_idle_low", spi_sclk, 0);
          if (!pc && in_frame) begin
            chk("rising_edges", nrise, 24);
            chk("csn_low_width", low_cnt, 50 * CLK_DIV);
            chk("frame_word", shv, exp_frame(nfr));
            if (nfr < 64) cap[nfr] = shv;
            nfr++;
            in_frame = 1'b0; have_prev = 1'b1; gap_cnt = 0;
          end
          gap_cnt++;
        end
        pc = spi_csn; ps = spi_sclk; pd = spi_sdio;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_within_budget", done, 1);
  endtask

  task automatic wait_frame3(input int budget);
    int k;
    k = 0;
    while (!(nfr == 3 && spi_csn == 1'b0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_frame3", (nfr == 3 && spi_csn == 1'b0), 1);
  endtask

  initial begin
    for (int i = 0; i < LUT_SIZE; i++)
      lut_tbl[i] = {3'(i), 13'(32'h100 + i), 8'(i * 7 + 3)};
    lut_tbl[0]  = 24'h00003C;
    lut_tbl[1]  = 24'hE012AB;
    lut_tbl[10] = 24'h0017B4;
    lut_tbl[17] = 24'h023201;

    // Reset values
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", spi_csn, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_sdio", spi_sdio, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_index", lut_index, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Full table walk with a stray start pulse during frame 3
    test_id = 1;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    wait_frame3(3000);
    repeat (20) @(posedge clk);
    #1;
    pulse_start();
    wait_done(20000);
    chk("full_frames", nfr, LUT_SIZE);
    chk("full_busy", busy, 0);
    chk("full_index", lut_index, LUT_SIZE);
    chk("full_error", error, 0);
    chk("frame0_lit", cap[0], 24'h00003C);
    chk("frame1_addr_mask_lit", cap[1], 24'h0012AB);
    chk("frame10_lit", cap[10], 24'h0017B4);
    chk("frame17_lit", cap[17], 24'h023201);
    repeat (10) @(posedge clk);
    #1;
    chk("done_level_held", done, 1);

    // Terminator entry at index 5
    test_id = 2;
    term_mode = 1'b1;
    pulse_start();
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    wait_done(5000);
    chk("term_frames", nfr, 5);
    chk("term_index", lut_index, 5);
    chk("term_busy", busy, 0);

    // Reset in the middle of frame 3
    test_id = 3;
    term_mode = 1'b0;
    pulse_start();
    wait_frame3(3000);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_csn", spi_csn, 1);
    chk("midrst_sclk", spi_sclk, 0);
    chk("midrst_sdio", spi_sdio, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_index", lut_index, 0);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("post_rst_idle_csn", spi_csn, 1);
    chk("post_rst_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
